mole_scheduler: RTL and testbench

Sequences the four mole outputs of the advanced whack-a-mole game. It decides which hole pops up, for how long, and with what gap between moles. It classifies player presses as hits or misses and ramps difficulty by shortening the mole up-time. It sits between the debounced button inputs and the score/lives logic, which consumes its hit_ok and miss pulses.

---
 rtl/mole_scheduler.sv | 136 +++++++++++++
 tb/tb_mole_scheduler.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mole_scheduler.sv
// Whack-a-mole sequencer: picks the next hole, times the gap and up windows,
// classifies presses as hits or misses and ramps difficulty by shortening up-time.
module mole_scheduler #(
   parameter int unsigned UP_BASE        = 32'd50000000,
   parameter int unsigned UP_STEP        = 32'd5000000,
   parameter int unsigned UP_MIN         = 32'd10000000,
   parameter int unsigned GAP_CYCLES     = 32'd25000000,
   parameter int unsigned HITS_PER_LEVEL = 32'd5,
   parameter int unsigned MAX_LEVEL      = 32'd7,
   parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic [3:0] hit,
   output logic [3:0] mole,
   output logic       hit_ok,
   output logic       miss,
   output logic [2:0] level,
   output logic [1:0] state
);

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_GAP  = 2'b01,
      S_UP   = 2'b10
   } state_t;

   localparam logic [2:0] LEVEL_MAX = 3'(MAX_LEVEL);

   state_t      r_state;
   logic [31:0] r_count;
   logic [31:0] r_hits;
   logic [1:0]  r_prevHole;
   logic [15:0] r_lfsr;
   logic [3:0]  r_mole;
   logic        r_hitOk;
   logic        r_miss;
   logic [2:0]  r_level;

   logic        w_feedback;
   logic [1:0]  w_hole;
   logic        w_litHit;
   logic [31:0] w_hitsNext;
   logic [31:0] w_stepTotal;
   logic [31:0] w_upTime;

   assign w_feedback  = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];
   assign w_hole      = (r_lfsr[1:0] == r_prevHole) ? r_lfsr[1:0] + 2'd1 : r_lfsr[1:0];
   assign w_litHit    = |(hit & r_mole);
   assign w_hitsNext  = r_hits + 32'd1;

   // Clamp to UP_MIN before subtracting so the 32-bit difference never wraps
   assign w_stepTotal = 32'(r_level) * UP_STEP;
   assign w_upTime    = (w_stepTotal >= UP_BASE || (UP_BASE - w_stepTotal) < UP_MIN) ?
                        UP_MIN : UP_BASE - w_stepTotal;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_count    <= 32'd0;
         r_hits     <= 32'd0;
         r_prevHole <= 2'd0;
         r_lfsr     <= LFSR_SEED;
         r_mole     <= 4'd0;
         r_hitOk    <= 1'b0;
         r_miss     <= 1'b0;
         r_level    <= 3'd0;
      end else begin
         r_lfsr  <= {w_feedback, r_lfsr[15:1]};
         r_hitOk <= 1'b0;
         r_miss  <= 1'b0;
         if (!enable) begin
            r_state <= S_IDLE;
            r_mole  <= 4'd0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  r_state <= S_GAP;
                  r_count <= GAP_CYCLES;
                  r_level <= 3'd0;
                  r_hits  <= 32'd0;
               end
               S_GAP: begin
                  if (r_count <= 32'd1) begin
                     r_state    <= S_UP;
                     r_count    <= w_upTime;
                     r_mole     <= 4'b0001 << w_hole;
                     r_prevHole <= w_hole;
                  end else begin
                     r_count <= r_count - 32'd1;
                  end
               end
               S_UP: begin
                  // A lit-hole press wins over timeout and over any wrong press
                  if (w_litHit) begin
                     r_hitOk <= 1'b1;
                     r_mole  <= 4'd0;
                     r_state <= S_GAP;
                     r_count <= GAP_CYCLES;
                     if (w_hitsNext >= HITS_PER_LEVEL) begin
                        r_hits <= 32'd0;
                        if (r_level != LEVEL_MAX) begin
                           r_level <= r_level + 3'd1;
                        end
                     end else begin
                        r_hits <= w_hitsNext;
                     end
                  end else if (r_count <= 32'd1) begin
                     r_miss  <= 1'b1;
                     r_mole  <= 4'd0;
                     r_state <= S_GAP;
                     r_count <= GAP_CYCLES;
                  end else begin
                     r_count <= r_count - 32'd1;
                     if (hit != 4'd0) begin
                        r_miss <= 1'b1;
                     end
                  end
               end
               default: begin
                  r_state <= S_IDLE;
                  r_mole  <= 4'd0;
               end
            endcase
         end
      end
   end

   assign mole   = r_mole;
   assign hit_ok = r_hitOk;
   assign miss   = r_miss;
   assign level  = r_level;
   assign state  = r_state;

endmodule

// File: tb/tb_mole_scheduler.sv
// Self-checking bench for mole_scheduler: directed scenarios plus a randomized
// run, every cycle compared against a phase/elapsed-time reference model.
module tb_mole_scheduler;

   localparam int UP_BASE        = 20;
   localparam int UP_STEP        = 4;
   localparam int UP_MIN         = 8;
   localparam int GAP_CYCLES     = 5;
   localparam int HITS_PER_LEVEL = 2;
   localparam int MAX_LEVEL      = 3;

   localparam int M_IDLE = 0;
   localparam int M_GAP  = 1;
   localparam int M_UP   = 2;

   logic       clk;
   logic       reset;
   logic       enable;
   logic [3:0] hit;
   logic [3:0] mole;
   logic       hit_ok;
   logic       miss;
   logic [2:0] level;
   logic [1:0] state;

   int total = 0;
   int bad   = 0;

   int         mState;
   int         mElapsed;
   int         mUpLen;
   int         mPrev;
   int         mHits;
   int         mLevel;
   int         mLfsr;
   int         pops;
   logic [3:0] mMole;
   logic       mHitOk;
   logic       mMiss;
   logic [3:0] lastPopMole;
   logic [3:0] seenMole;

   mole_scheduler #(
      .UP_BASE(UP_BASE),
      .UP_STEP(UP_STEP),
      .UP_MIN(UP_MIN),
      .GAP_CYCLES(GAP_CYCLES),
      .HITS_PER_LEVEL(HITS_PER_LEVEL),
      .MAX_LEVEL(MAX_LEVEL),
      .LFSR_SEED(16'hACE1)
   ) dut (
      .clk(clk),
      .reset(reset),
      .enable(enable),
      .hit(hit),
      .mole(mole),
      .hit_ok(hit_ok),
      .miss(miss),
      .level(level),
      .state(state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Up-time rule in plain signed arithmetic: base minus level steps, floored
   function automatic int upTime(input int lvl);
      int t;
      t = UP_BASE - lvl * UP_STEP;
      if (t < UP_MIN) t = UP_MIN;
      return t;
   endfunction

   task automatic modelReset();
      mState      = M_IDLE;
      mElapsed    = 0;
      mUpLen      = 0;
      mPrev       = 0;
      mHits       = 0;
      mLevel      = 0;
      mLfsr       = 16'hACE1;
      mMole       = 4'd0;
      mHitOk      = 1'b0;
      mMiss       = 1'b0;
      lastPopMole = 4'd0;
      seenMole    = 4'd0;
   endtask

   // One clock edge of the game rules, given the inputs present at that edge
   task automatic stepModel(input logic en, input logic [3:0] hv);
      int h;
      int b;
      mHitOk = 1'b0;
      mMiss  = 1'b0;
      if (!en) begin
         mState = M_IDLE;
         mMole  = 4'd0;
      end else if (mState == M_IDLE) begin
         mState   = M_GAP;
         mElapsed = 0;
         mLevel   = 0;
         mHits    = 0;
      end else if (mState == M_GAP) begin
         mElapsed++;
         if (mElapsed == GAP_CYCLES) begin
            h = mLfsr % 4;
            if (h == mPrev) h = (h + 1) % 4;
            mPrev    = h;
            mMole    = 4'(1 << h);
            mState   = M_UP;
            mElapsed = 0;
            mUpLen   = upTime(mLevel);
            pops++;
         end
      end else begin
         if (hv[mPrev[1:0]]) begin
            mHitOk   = 1'b1;
            mMole    = 4'd0;
            mState   = M_GAP;
            mElapsed = 0;
            mHits++;
            if (mHits == HITS_PER_LEVEL) begin
               mHits = 0;
               if (mLevel < MAX_LEVEL) mLevel++;
            end
         end else begin
            mElapsed++;
            if (mElapsed == mUpLen) begin
               mMiss    = 1'b1;
               mMole    = 4'd0;
               mState   = M_GAP;
               mElapsed = 0;
            end else if (hv != 4'd0) begin
               mMiss = 1'b1;
            end
         end
      end
      b     = (mLfsr ^ (mLfsr >> 2) ^ (mLfsr >> 3) ^ (mLfsr >> 5)) & 1;
      mLfsr = (mLfsr >> 1) | (b << 15);
   endtask

   task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic checkOutput(input string tag);
      checkValue({tag, ".mole"},   32'(mole),   32'(mMole));
      checkValue({tag, ".hit_ok"}, 32'(hit_ok), 32'(mHitOk));
      checkValue({tag, ".miss"},   32'(miss),   32'(mMiss));
      checkValue({tag, ".level"},  32'(level),  32'(mLevel));
      checkValue({tag, ".state"},  32'(state),  32'(mState));
   endtask

   task automatic applyStimulus(input logic en, input logic [3:0] hv, input string tag);
      enable = en;
      hit    = hv;
      @(posedge clk);
      #1;
      stepModel(en, hv);
      checkOutput(tag);
      if (mole !== 4'd0 && seenMole === 4'd0) begin
         if (lastPopMole !== 4'd0) begin
            total++;
            assert (mole !== lastPopMole) else begin
               bad++;
               $error("[TB] FAIL %s.repeat: observed=%0h required!=%0h", tag, mole, lastPopMole);
            end
         end
         lastPopMole = mole;
      end
      seenMole = mole;
   endtask

   task automatic waitUp(input string tag);
      int n;
      n = 0;
      while (state !== 2'b10 && n < 200) begin
         applyStimulus(1'b1, 4'd0, tag);
         n++;
      end
      checkValue({tag, ".reach_up"}, 32'(state), 32'd2);
   endtask

   // Called on the first UP cycle; counts how many cycles the mole stays lit
   task automatic measureUp(input string tag, input int expLen);
      int n;
      n = 1;
      while (mole !== 4'd0 && n < 100) begin
         applyStimulus(1'b1, 4'd0, tag);
         if (mole !== 4'd0) n++;
      end
      checkValue({tag, ".len"},   32'(n),     32'(expLen));
      checkValue({tag, ".miss"},  32'(miss),  32'd1);
      checkValue({tag, ".state"}, 32'(state), 32'd1);
   endtask

   initial begin
      logic [3:0] wrong;
      logic [3:0] hv;
      logic       en;
      int         r;
      int         c;

      reset  = 1'b1;
      enable = 1'b0;
      hit    = 4'd0;
      pops   = 0;
      modelReset();
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset");
      @(negedge clk);
      reset = 1'b0;

      // Start: gap of GAP_CYCLES, then a one-hot mole at level 0
      applyStimulus(1'b1, 4'd0, "start");
      checkValue("start.state", 32'(state), 32'd1);
      waitUp("first_up");
      checkValue("first_up.level", 32'(level), 32'd0);

      // Untouched mole times out after the level-0 window
      measureUp("timeout_l0", 20);
      checkValue("timeout_l0.level", 32'(level), 32'd0);

      // Two correct hits on UP cycle 3 advance to level 1
      for (int k = 0; k < 2; k++) begin
         waitUp("hit_c3");
         applyStimulus(1'b1, 4'd0, "hit_c3");
         applyStimulus(1'b1, 4'd0, "hit_c3");
         applyStimulus(1'b1, mMole, "hit_c3");
         checkValue("hit_c3.hit_ok", 32'(hit_ok), 32'd1);
         checkValue("hit_c3.mole",   32'(mole),   32'd0);
      end
      checkValue("level1", 32'(level), 32'd1);
      waitUp("timeout_l1");
      measureUp("timeout_l1", 16);

      // Wrong press keeps the mole up; lit plus wrong together is a clean hit
      waitUp("wrong");
      wrong = {mMole[2:0], mMole[3]};
      applyStimulus(1'b1, wrong, "wrong");
      checkValue("wrong.miss",  32'(miss),  32'd1);
      checkValue("wrong.state", 32'(state), 32'd2);
      applyStimulus(1'b1, mMole | wrong, "both");
      checkValue("both.hit_ok", 32'(hit_ok), 32'd1);
      checkValue("both.miss",   32'(miss),   32'd0);

      // Eight more hits push level to saturation and the floor up-time
      for (int k = 0; k < 8; k++) begin
         waitUp("ramp");
         applyStimulus(1'b1, mMole, "ramp");
      end
      checkValue("ramp.level", 32'(level), 32'd3);
      waitUp("timeout_l3");
      measureUp("timeout_l3", 8);

      // Enable dropped mid-UP, even with a lit press, goes silently to IDLE
      waitUp("drop");
      applyStimulus(1'b1, 4'd0, "drop");
      applyStimulus(1'b0, mMole, "drop");
      checkValue("drop.state",  32'(state),  32'd0);
      checkValue("drop.mole",   32'(mole),   32'd0);
      checkValue("drop.hit_ok", 32'(hit_ok), 32'd0);
      checkValue("drop.level",  32'(level),  32'd3);
      applyStimulus(1'b1, 4'd0, "restart");
      checkValue("restart.level", 32'(level), 32'd0);

      // Reach level 1, then assert reset in the middle of a gap
      for (int k = 0; k < 2; k++) begin
         waitUp("pre_reset");
         applyStimulus(1'b1, mMole, "pre_reset");
      end
      applyStimulus(1'b1, 4'd0, "pre_reset");
      checkValue("pre_reset.level", 32'(level), 32'd1);
      hit   = 4'd0;
      reset = 1'b1;
      #2;
      modelReset();
      checkValue("async_reset.state", 32'(state), 32'd0);
      checkValue("async_reset.level", 32'(level), 32'd0);
      checkValue("async_reset.mole",  32'(mole),  32'd0);
      @(negedge clk);
      reset  = 1'b0;
      enable = 1'b0;
      applyStimulus(1'b0, 4'd0, "post_reset");

      // Randomized play until at least 50 pops have been observed
      pops = 0;
      for (c = 0; c < 4000 && pops < 50; c++) begin
         en = ($urandom_range(0, 99) != 0);
         r  = $urandom_range(0, 9);
         hv = 4'd0;
         if (r < 2) hv = mMole;
         else if (r == 2) hv = 4'($urandom_range(1, 15)) & ~mMole;
         else if (r == 3) hv = mMole | 4'($urandom_range(0, 15));
         else if (r == 4) hv = 4'($urandom_range(0, 15));
         applyStimulus(en, hv, "random");
      end
      if (pops < 50) begin
         bad++;
         $display("[TB] FAIL random.pops: observed=%0d required=50", pops);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
